if_stage: RTL and testbench

- Instruction-fetch stage of the Mini RISC-V CPU core, sitting directly upstream of decode inside `main`.
- Owns the program counter and drives a synchronous-read instruction memory with 1-cycle latency.
- Presents {pc, pc+4, instruction} to decode under a stall/redirect protocol.
- Maintains a retired-fetch counter and a sticky misaligned-redirect flag.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/if_stage.sv | 87 ++++++++
 tb/tb_if_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the Mini RISC-V core: datapath width, reset vector,
// canonical NOP encoding and the fetch-stage state encoding.
package riscv_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous imem and hands
// {pc, pc+4, inst} to decode under a stall/redirect/halt protocol.
module if_stage
  import riscv_pkg::*;
#(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC,
  parameter int               IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pc4,
  output logic [31:0]        out_inst,
  output logic               misalign_err,
  output logic [31:0]        inst_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] req_pc, rsp_pc, fetch_pc;
  logic            rsp_valid;
  logic            redir;

  // Redirects only mean something once the pipeline is running.
  assign redir    = (state == RUN) & redirect_valid;
  assign fetch_pc = redir ? {redirect_pc[XLEN-1:2], 2'b00} : req_pc;

  always_comb begin
    imem_en = 1'b0;
    unique case (state)
      BOOT:    imem_en = rst;  // keep the memory idle while reset is held
      RUN:     imem_en = redirect_valid | ~stall;
      default: imem_en = 1'b0;
    endcase
  end

  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign out_valid = rsp_valid & ~redir;
  assign out_inst  = out_valid ? imem_rdata : INST_NOP;
  assign out_pc    = rsp_pc;
  assign out_pc4   = rsp_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      req_pc       <= RESET_PC;
      rsp_pc       <= RESET_PC;
      rsp_valid    <= 1'b0;
      misalign_err <= 1'b0;
      inst_count   <= 32'd0;
    end else begin
      if (out_valid && !stall)
        inst_count <= inst_count + 32'd1;
      unique case (state)
        BOOT: begin
          state     <= RUN;
          rsp_pc    <= RESET_PC;
          rsp_valid <= 1'b1;
          req_pc    <= RESET_PC + XLEN'(4);
        end
        RUN: begin
          if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            misalign_err <= 1'b1;
          // Halt takes effect only once the current output has been accepted.
          if (halt && !stall && !redirect_valid) begin
            state     <= HALT;
            rsp_valid <= 1'b0;
          end else if (imem_en) begin
            rsp_pc    <= fetch_pc;
            rsp_valid <= 1'b1;
            req_pc    <= fetch_pc + XLEN'(4);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: an instruction-stream model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_if_stage;
  import riscv_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic          stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          out_valid, misalign_err;
  logic [31:0]   out_pc, out_pc4, out_inst, inst_count;

  if_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst),
    .misalign_err(misalign_err), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  typedef struct {
    bit          v;
    bit          en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
    bit          mis;
  } exp_t;
  exp_t sbq[$];

  int ntests = 0, nfail = 0;

  // Model of the instruction stream as decode sees it.
  bit          m_boot, m_halt;
  logic [31:0] m_pc, m_nxt, m_cnt;
  bit          m_mis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_cnt = 0; m_mis = 0;
    m_pc = 32'h0; m_nxt = 32'h0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.v = 0; e.en = 0; e.pc = 0; e.inst = INST_NOP; e.cnt = 0; e.mis = 0;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic cyc(input bit st, input bit rv, input logic [31:0] rp, input bit h);
    exp_t e;
    stall = st; redirect_valid = rv; redirect_pc = rp; halt = h;
    e.cnt = m_cnt; e.mis = m_mis; e.pc = m_pc; e.inst = INST_NOP;
    if (m_boot) begin
      e.v = 0; e.en = 1;
      m_boot = 0; m_pc = 32'h0; m_nxt = 32'h4;
    end else if (m_halt) begin
      e.v = 0; e.en = 0;
    end else begin
      e.v  = !rv;
      e.en = rv || !st;
      if (e.v) e.inst = mem[m_pc[AW+1:2]];
      if (e.v && !st) m_cnt = m_cnt + 1;
      if (rv) begin
        if (rp[1:0] != 2'b00) m_mis = 1;
        m_pc  = {rp[31:2], 2'b00};
        m_nxt = m_pc + 4;
      end else if (!st) begin
        if (h) m_halt = 1;
        else begin m_pc = m_nxt; m_nxt = m_nxt + 4; end
      end
    end
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 0; stall = 0; redirect_valid = 0; halt = 0;
    model_reset();
    push_reset_exp();
    @(negedge clk);
    rst = 1;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
        chk("imem_en", {31'd0, imem_en}, {31'd0, e.en});
        chk("out_inst", out_inst, e.inst);
        chk("inst_count", inst_count, e.cnt);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        if (e.v) begin
          chk("out_pc", out_pc, e.pc);
          chk("out_pc4", out_pc4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] rp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093; mem[1] = 32'h00a0_0113;
    mem[2] = 32'h0020_81b3; mem[3] = 32'h0000_0013;

    rst = 0;
    model_reset();
    @(negedge clk);
    push_reset_exp();
    #7 rst = 1;
    @(negedge clk);

    cyc(0, 0, 0, 0);                        // BOOT
    repeat (4) cyc(0, 0, 0, 0);             // pc 0,4,8,C
    cyc(0, 1, 32'h0, 0);                    // back to 0
    cyc(0, 0, 0, 0);                        // pc 0
    repeat (3) cyc(1, 0, 0, 0);             // hold pc 4
    cyc(0, 0, 0, 0);                        // pc 4 accepted
    cyc(0, 1, 32'h40, 0);                   // at pc 8, redirect
    cyc(1, 1, 32'h20, 0);                   // redirect + stall
    cyc(0, 1, 32'h42, 0);                   // misaligned redirect
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFC, 0);            // wrap-around path
    repeat (3) cyc(0, 0, 0, 0);             // FFFFFFFC, 0, 4
    cyc(1, 0, 0, 1);                        // halt + stall at pc 8: ignored
    cyc(0, 0, 0, 0);                        // pc 8
    cyc(0, 0, 0, 1);                        // halt at pc C
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h80, 0);                   // redirect in HALT does nothing
    rst_pulse();
    cyc(0, 0, 0, 0);                        // BOOT
    repeat (3) cyc(0, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      if (m_halt && ($urandom_range(0, 3) == 0)) begin
        rst_pulse();
      end else begin
        r  = $urandom_range(0, 99);
        rp = $urandom;
        if ($urandom_range(0, 1) == 1) rp = {16'h0, rp[15:0]};
        cyc(r < 30, (r % 7) == 0, rp, $urandom_range(0, 49) == 0);
      end
    end

    #3;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
